// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side write handshake (strobe, word, ready) for uart_tx.
interface uart_tx_if #(
    parameter int DATAWIDTH = 8
);
    logic                 tx_start;
    logic [DATAWIDTH-1:0] din;
    logic                 tx_ready;
    modport master (output tx_start, din, input tx_ready);
    modport slave (input tx_start, din, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-deep holding buffer, shared 16x s_tick baud strobe.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd via parity_odd).
module uart_tx #(
    parameter int DATAWIDTH = 8,
    parameter int SB_TICK   = 16
) (
    input  logic     clk,
    input  logic     tx_rst_n,
    input  logic     tx_en,
    input  logic     s_tick,
`ifdef UART_TX_PARITY_EN
    input  logic     parity_odd,
`endif
    uart_tx_if.slave host,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t POST_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t POST_DATA = STOP;
`endif
    localparam logic [2:0] BIT_LAST  = 3'(DATAWIDTH - 1);
    localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);

    state_t               state, state_n;
    logic [5:0]           s_cnt, s_cnt_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DATAWIDTH-1:0] shreg, shreg_n, hold_q;
    logic                 hold_full, load, tx_n, done_n;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    assign host.tx_ready = !hold_full;

    always_ff @(posedge clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            tx        <= tx_n;
            tx_busy   <= state_n != IDLE;
            tx_done   <= done_n;
            // a transfer in the same cycle as tx_start wins: the buffer was full, so the strobe is dropped
            hold_full <= load ? 1'b0 : (hold_full || host.tx_start);
            if (host.tx_start && !hold_full) hold_q <= host.din;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        done_n    = 1'b0;
        load      = 1'b0;
        if (tx_en && s_tick && state != IDLE) s_cnt_n = s_cnt + 6'd1;
        if (tx_en) begin
            case (state)
                IDLE:  load = hold_full;
                START: if (s_tick && s_cnt == 6'd15) begin
                    state_n   = DATA;
                    s_cnt_n   = '0;
                    bit_cnt_n = '0;
                end
                DATA:  if (s_tick && s_cnt == 6'd15) begin
                    shreg_n   = shreg >> 1;
                    s_cnt_n   = '0;
                    state_n   = bit_cnt == BIT_LAST ? POST_DATA : DATA;
                    bit_cnt_n = bit_cnt + 3'd1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (s_tick && s_cnt == 6'd15) begin
                    state_n = STOP;
                    s_cnt_n = '0;
                end
`endif
                STOP:  if (s_tick && s_cnt == STOP_LAST) begin
                    done_n  = 1'b1;
                    s_cnt_n = '0;
                    state_n = IDLE;
                    load    = hold_full;
                end
                default: ;
            endcase
        end
        if (load) begin
            state_n = START;
            s_cnt_n = '0;
            shreg_n = hold_q;
        end
`ifdef UART_TX_PARITY_EN
        par_n = load ? (^hold_q ^ parity_odd) : par;
`endif
        tx_n = state_n == START ? 1'b0 :
               state_n == DATA  ? shreg_n[0] :
`ifdef UART_TX_PARITY_EN
               state_n == PARITY ? par_n :
`endif
               1'b1;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench; a line decoder rebuilds frames from tx
// in effective (enabled) tick time and tests compare them with the words they wrote.
module tb_uart_tx;
    localparam int DW = 8;
    localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB    = 1 + DW + PB;
    localparam int FRAME = 16 * NB + SB;

    logic clk = 0, tx_rst_n = 0, tx_en = 1, s_tick = 0, parity_odd = 0;
    logic tx, tx_busy, tx_done;
    int   tick_per = 4, cmp = 0, errs = 0;

    uart_tx_if #(.DATAWIDTH(DW)) host();

    uart_tx #(.DATAWIDTH(DW), .SB_TICK(SB)) dut (
        .clk(clk), .tx_rst_n(tx_rst_n), .tx_en(tx_en), .s_tick(s_tick),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .host(host), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int tc = 0;
        forever begin
            @(negedge clk);
            if (tc + 1 >= tick_per) begin tc = 0; s_tick = 1; end
            else begin tc++; s_tick = 0; end
        end
    end

    // Line decoder: record = {data, parity, bits stable/levels ok, tx_done at frame end, started back-to-back}
    logic [11:0] got[$], exp_q[$];
    bit          mon_on = 0, in_f = 0, ok, b2b;
    int          t, cur_k, k, stray = 0;
    logic        cur_v, p;
    logic [7:0]  d;

    always @(negedge clk) begin
        #1;
        if (!mon_on) in_f = 0;
        else begin
            if (in_f && t == FRAME) begin
                got.push_back({d, p, ok, tx_done === 1'b1, b2b});
                in_f = 0;
                if (tx === 1'b0) begin in_f = 1; t = 0; cur_k = -1; ok = 1; b2b = 1; d = 0; p = 0; end
            end else begin
                if (tx_done === 1'b1) stray++;
                if (!in_f && tx === 1'b0) begin in_f = 1; t = 0; cur_k = -1; ok = 1; b2b = 0; d = 0; p = 0; end
            end
            if (in_f) begin
                k = t / 16;
                if (k != cur_k) begin
                    cur_k = k;
                    cur_v = tx;
                    if (k >= 1 && k <= DW) d[k-1] = tx;
                    if (PB == 1 && k == DW + 1) p = tx;
                end else if (tx !== cur_v) ok = 0;
                if ((k == 0 && tx !== 1'b0) || (k >= NB && tx !== 1'b1) || tx_busy !== 1'b1) ok = 0;
                if (s_tick === 1'b1 && tx_en === 1'b1) t++;
            end
        end
    end

    function automatic logic [11:0] exp_rec(input logic [7:0] v, input logic podd, input logic bb);
        return {v, PB == 1 ? (^v ^ podd) : 1'b0, 2'b11, bb};
    endfunction

    task automatic write(input logic [7:0] v, input bit wait_rdy);
        int n = 0;
        @(negedge clk);
        while (wait_rdy && tx_ready_now() !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin
            cmp++; errs++;
            $display("FAIL write_ready_timeout: tx_ready=%b after %0d clk, required 1", host.tx_ready, n);
        end
        host.tx_start = 1; host.din = v;
        @(negedge clk);
        host.tx_start = 0;
    endtask

    function automatic logic tx_ready_now();
        return host.tx_ready;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(tx_busy === 1'b0 && host.tx_ready === 1'b1 && !in_f) && n < 20000);
        @(negedge clk);
        cmp++;
        if (n >= 20000) begin errs++; $display("FAIL %s_idle_timeout: busy=%b ready=%b after %0d clk", tag, tx_busy, host.tx_ready, n); end
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        cmp++;
        if ({tx, tx_busy, tx_done, host.tx_ready} !== 4'b1001) begin
            errs++; $display("FAIL reset_hold: tx/busy/done/ready=%b required 1001", {tx, tx_busy, tx_done, host.tx_ready});
        end
        tx_rst_n = 1;
        write(8'h5A, 1);
        repeat (200) @(negedge clk);
        cmp++;
        if (tx_busy !== 1'b1) begin errs++; $display("FAIL reset_prebusy: busy=%b required 1", tx_busy); end
        @(posedge clk); #2 tx_rst_n = 0;
        #1;
        cmp++;
        if ({tx, tx_busy, tx_done, host.tx_ready} !== 4'b1001) begin
            errs++; $display("FAIL reset_async: tx/busy/done/ready=%b required 1001", {tx, tx_busy, tx_done, host.tx_ready});
        end
        @(negedge clk); tx_rst_n = 1;
        repeat (100) begin @(negedge clk); if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++; end
        cmp++;
        if (bad != 0) begin errs++; $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad); end
        got.delete(); exp_q.delete(); stray = 0; mon_on = 1;
    endtask

    task automatic test_single();
        logic [11:0] a, e;
        stray = 0;
        write(8'h55, 1);
        exp_q.push_back(exp_rec(8'h55, parity_odd, 0));
        cmp++;
        if (host.tx_ready !== 1'b0) begin errs++; $display("FAIL single_ready_low: tx_ready=%b required 0", host.tx_ready); end
        @(negedge clk);
        cmp++;
        if ({host.tx_ready, tx} !== 2'b10) begin errs++; $display("FAIL single_start: ready/tx=%b required 10", {host.tx_ready, tx}); end
        wait_idle("single");
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL single_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL single_frame: decoded %03h required %03h", a, e); end
        end
        cmp++;
        if (stray != 0) begin errs++; $display("FAIL single_done_pulses: %0d extra tx_done cycles, required 0", stray); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [11:0] a, e;
        stray = 0;
        write(8'hA3, 1); exp_q.push_back(exp_rec(8'hA3, parity_odd, 0));
        write(8'h3C, 1); exp_q.push_back(exp_rec(8'h3C, parity_odd, 1));
        wait_idle("b2b");
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL b2b_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL b2b_frame: decoded %03h required %03h", a, e); end
        end
        cmp++;
        if (stray != 0) begin errs++; $display("FAIL b2b_done_pulses: %0d extra tx_done cycles, required 0", stray); end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_overrun();
        logic [11:0] a, e;
        write(8'h11, 1); exp_q.push_back(exp_rec(8'h11, parity_odd, 0));
        write(8'h22, 1); exp_q.push_back(exp_rec(8'h22, parity_odd, 1));
        cmp++;
        if (host.tx_ready !== 1'b0) begin errs++; $display("FAIL overrun_ready: tx_ready=%b required 0", host.tx_ready); end
        write(8'h33, 0);
        wait_idle("overrun");
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL overrun_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL overrun_frame: decoded %03h required %03h", a, e); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_en_gating();
        logic [11:0] a, e;
        logic [7:0]  v = 8'($urandom);
        logic        lv;
        int          n = 0, bad = 0;
        write(v, 1); exp_q.push_back(exp_rec(v, parity_odd, 0));
        while (!(in_f && t >= 16 * 3 + 5) && n < 5000) begin @(negedge clk); n++; end
        tx_en = 0; lv = tx;
        repeat (50) begin @(negedge clk); if (tx !== lv || tx_busy !== 1'b1) bad++; end
        tx_en = 1;
        cmp++;
        if (bad != 0 || n >= 5000) begin errs++; $display("FAIL en_freeze: %0d changed cycles (wait %0d clk), required 0", bad, n); end
        wait_idle("en");
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL en_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL en_frame: decoded %03h required %03h", a, e); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [11:0] a, e;
        logic [7:0]  v;
        stray = 0;
        tick_per = $urandom_range(2, 5);
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            write(v, 1);
            exp_q.push_back(exp_rec(v, parity_odd, i != 0));
        end
        wait_idle("random");
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL random_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL random_frame: decoded %03h required %03h (tick period %0d)", a, e, tick_per); end
        end
        cmp++;
        if (stray != 0) begin errs++; $display("FAIL random_done_pulses: %0d extra tx_done cycles, required 0", stray); end
        got.delete(); exp_q.delete();
        tick_per = 4;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [11:0] a, e;
        for (int i = 0; i < 2; i++) begin
            parity_odd = i[0];
            write(8'h07, 1); exp_q.push_back(exp_rec(8'h07, parity_odd, 0));
            wait_idle("parity");
        end
        cmp++;
        if (got.size() != exp_q.size()) begin errs++; $display("FAIL parity_count: %0d frames, required %0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            a = got.pop_front(); e = exp_q.pop_front(); cmp++;
            if (a !== e) begin errs++; $display("FAIL parity_frame: decoded %03h required %03h", a, e); end
        end
        got.delete(); exp_q.delete();
        parity_odd = 0;
    endtask
`endif

    initial begin
        host.tx_start = 0;
        host.din = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_en_gating();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; companion to the existing oversampled UART receiver, same frame format and shared baud tick.
- Serialises DATAWIDTH-bit words on a single line: 1 start bit (low), data LSB first, optional parity, stop period of SB_TICK ticks (high).
- One-deep holding buffer allows back-to-back frames with no idle gap.
- Sits between the host-side byte interface and the tx pin; driven by the same s_tick baud generator as the receiver.

Parameters:
- DATAWIDTH, 8, data bits per frame (5..8)
- SB_TICK, 16, s_tick count for the stop period (16/24/32 = 1/1.5/2 stop bits)

Ports:
- clk  in  1  system clock
- tx_rst_n  in  1  asynchronous active-low reset
- tx_en  in  1  enable; low freezes frame progress
- s_tick  in  1  16x-baud strobe, one clk wide
- tx_start  in  1  write strobe for din
- din  in  DATAWIDTH  word to send
- tx_ready  out  1  holding buffer empty, tx_start accepted
- tx  out  1  serial line, idle high
- tx_busy  out  1  frame in progress (state != IDLE)
- tx_done  out  1  one-clk pulse at end of stop period

Behaviour:
- Reset (async, tx_rst_n=0): tx=1, tx_busy=0, tx_done=0, tx_ready=1. Buffer empty, FSM IDLE, counters 0. Mid-frame reset aborts immediately: tx goes high without waiting for clk.
- All outputs registered.
- Holding buffer:
  - tx_start with tx_ready=1 captures din; tx_ready goes 0 next cycle.
  - tx_start with tx_ready=0 is ignored; the buffer is never overwritten.
  - Capture is allowed regardless of tx_en.
  - tx_ready returns to 1 the cycle after the buffer is transferred to the shift register.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- The FSM advances only when tx_en=1. With tx_en=0, state, tick counter and tx hold.
- Tick counter s_cnt counts s_tick pulses.
- IDLE:
  - If the buffer is full and tx_en=1: load shift register, empty buffer, s_cnt=0, go to START.
  - tx=0 from the next clk.
- START: tx=0. On the s_tick where s_cnt==15: go to DATA, s_cnt=0, bit_cnt=0.
- DATA:
  - tx = shift[0].
  - On the s_tick where s_cnt==15: shift right, s_cnt=0.
  - If bit_cnt==DATAWIDTH-1, go to PARITY or STOP; otherwise bit_cnt+1.
- STOP:
  - tx=1.
  - On the s_tick where s_cnt==SB_TICK-1: pulse tx_done for one clk.
  - If the buffer is full and tx_en=1: reload and go straight to START (no idle bit).
  - Otherwise go to IDLE.
- Frame length: 16*(1+DATAWIDTH[+1]) + SB_TICK ticks; the start edge follows the acceptance clk by 1-2 clk.
- Simultaneous tx_start and buffer transfer in the same clk: the transfer uses the old buffer contents; tx_start is ignored because tx_ready is still 0 that cycle.
- s_tick while in IDLE has no effect.

Optional Feature:
- UART_TX_PARITY_EN defined: adds a PARITY state after DATA. Lasts 16 ticks, tx = XOR of the data bits (even parity). New port parity_odd (in, 1): when high, the inverted value is sent. parity_odd is sampled at shift-register load.
- Undefined: no PARITY state, no parity_odd port, DATA goes directly to STOP.

Test Plan:
- Reset and idle: assert tx_rst_n=0 mid-frame -> tx=1, tx_busy=0, tx_ready=1 with no clk edge. Release, no stimulus -> tx stays 1.
- Single frame, din=0x55, s_tick every 4 clk -> line reads 0,1,0,1,0,1,0,1,0,1. Each bit is 16 ticks (64 clk), stop is 64 clk, tx_done pulses once. Total 160 ticks.
- Back-to-back: write 0xA3, then write 0x3C as soon as tx_ready=1 -> second start bit immediately follows the first frame's stop period with no extra idle. Two tx_done pulses, 160 ticks apart.
- Overrun: write 0x11, 0x22, then 0x33 while tx_ready=0 -> only 0x11 and 0x22 appear on tx; 0x33 is dropped.
- tx_en gating: drop tx_en for 50 clk mid-DATA with s_tick running -> tx level frozen and the bit stretched by exactly the paused ticks; the rest of the frame is correct.
- With UART_TX_PARITY_EN: din=0x07, parity_odd=0 -> parity bit 1; parity_odd=1 -> parity bit 0. Frame is 176 ticks.
